// File: rtl/tdm_demux4_pkg.sv
// Shared types for the 4-slot TDM receive path.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [1:0] slot_t;

    localparam int NUM_SLOTS = 4;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial TDM input and parallel channel-word output bundle.
interface tdm_demux4_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic              din;
    logic              frame;
    logic [DATA_W-1:0] o0;
    logic [DATA_W-1:0] o1;
    logic [DATA_W-1:0] o2;
    logic [DATA_W-1:0] o3;
    logic              frame_valid;
    logic              locked;
    logic              sync_err;

    modport master (
        output en, din, frame,
        input  o0, o1, o2, o3, frame_valid, locked, sync_err
    );

    modport slave (
        input  en, din, frame,
        output o0, o1, o2, o3, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4_frame_tracker.sv
// Frame position tracking: bit/slot counters, lock FSM and marker flywheel.
module tdm_frame_tracker
    import tdm_demux_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MISS_LIMIT = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  logic  frame_i,
    output slot_t slot_o,
    output logic  shift_o,
    output logic  eof_o,
    output logic  locked_o,
    output logic  sync_err_o
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_LIMIT);
    localparam slot_t         LAST_SLOT = slot_t'(NUM_SLOTS - 1);
    // Position just after slot 0 bit 0, where a freshly accepted marker leaves us.
    localparam logic [BW-1:0] P1_BIT  = (DATA_W == 1) ? '0 : BW'(1);
    localparam slot_t         P1_SLOT = (DATA_W == 1) ? slot_t'(1) : slot_t'(0);

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    slot_t           slot_q, slot_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            sync_err_q, sync_err_d;

    logic            at_start, last_bit;
    logic [BW-1:0]   bit_nx;
    slot_t           slot_nx;

    assign at_start = (bit_q == '0) && (slot_q == '0);
    assign last_bit = (bit_q == LAST_BIT);
    assign bit_nx   = last_bit ? '0 : bit_q + BW'(1);
    assign slot_nx  = last_bit ? slot_q + slot_t'(1) : slot_q;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        slot_d     = slot_q;
        miss_d     = miss_q;
        sync_err_d = 1'b0;
        shift_o    = 1'b0;
        eof_o      = 1'b0;
        // A marker always redirects the bit into slot 0.
        slot_o     = frame_i ? slot_t'(0) : slot_q;
        if (en_i) begin
            case (state_q)
                HUNT: begin
                    if (frame_i) begin
                        state_d = LOCKED;
                        shift_o = 1'b1;
                        bit_d   = P1_BIT;
                        slot_d  = P1_SLOT;
                        miss_d  = '0;
                    end
                end
                LOCKED: begin
                    if (at_start && !frame_i) begin
                        sync_err_d = 1'b1;
                        if (miss_q == MISS_MAX - MW'(1)) begin
                            state_d = HUNT;
                            bit_d   = '0;
                            slot_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d  = miss_q + MW'(1);
                            shift_o = 1'b1;
                            bit_d   = bit_nx;
                            slot_d  = slot_nx;
                        end
                    end else if (frame_i && !at_start) begin
                        sync_err_d = 1'b1;
                        shift_o    = 1'b1;
                        bit_d      = P1_BIT;
                        slot_d     = P1_SLOT;
                        miss_d     = '0;
                    end else begin
                        if (at_start) miss_d = '0;
                        shift_o = 1'b1;
                        eof_o   = last_bit && (slot_q == LAST_SLOT);
                        bit_d   = bit_nx;
                        slot_d  = slot_nx;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            bit_q      <= '0;
            slot_q     <= '0;
            miss_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            slot_q     <= slot_d;
            miss_q     <= miss_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign locked_o   = (state_q == LOCKED);
    assign sync_err_o = sync_err_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: shadow shift registers per slot, loaded
// into the output words at end of frame.
module tdm_demux4
    import tdm_demux_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MISS_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux4_if.slave  bus
);
    slot_t slot;
    logic  shift, eof;

    logic [NUM_SLOTS-1:0][DATA_W-1:0] sh_q, sh_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] out_q, out_d;
    logic                             fv_q;

    tdm_frame_tracker #(
        .DATA_W     (DATA_W),
        .MISS_LIMIT (MISS_LIMIT)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .en_i       (bus.en),
        .frame_i    (bus.frame),
        .slot_o     (slot),
        .shift_o    (shift),
        .eof_o      (eof),
        .locked_o   (bus.locked),
        .sync_err_o (bus.sync_err)
    );

    always_comb begin
        sh_d  = sh_q;
        if (shift) sh_d[slot] = (sh_q[slot] << 1) | DATA_W'(bus.din);
        // Final bit of slot 3 is taken from the next-state shadows.
        out_d = eof ? sh_d : out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            out_q <= '0;
            fv_q  <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            out_q <= out_d;
            fv_q  <= eof;
        end
    end

    assign bus.o0          = out_q[0];
    assign bus.o1          = out_q[1];
    assign bus.o2          = out_q[2];
    assign bus.o3          = out_q[3];
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 with DATA_W=4, MISS_LIMIT=2.
module tb_tdm_demux4;
    localparam int DW = 4;
    localparam int ML = 2;

    typedef logic [3:0][DW-1:0] words_t;
    typedef struct {
        words_t w;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t fq[$];
    int   eq[$];
    exp_t e;
    words_t last_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tdm_demux4_if #(.DATA_W(DW)) bus ();

    tdm_demux4 #(.DATA_W(DW), .MISS_LIMIT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares every output event against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_valid) begin
                if (fq.size() == 0) chk("frame_valid_unexpected", bus.frame_valid, 1'b0);
                else begin
                    e = fq.pop_front();
                    chk("fv_cycle", cyc, e.cyc);
                    chk("o0", bus.o0, e.w[0]);
                    chk("o1", bus.o1, e.w[1]);
                    chk("o2", bus.o2, e.w[2]);
                    chk("o3", bus.o3, e.w[3]);
                end
            end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
                chk("frame_valid_missing", bus.frame_valid, 1'b1);
                void'(fq.pop_front());
            end
            if (bus.sync_err) begin
                if (eq.size() == 0) chk("sync_err_unexpected", bus.sync_err, 1'b0);
                else chk("sync_err_cycle", cyc, eq.pop_front());
            end else if (eq.size() > 0 && eq[0] <= cyc) begin
                chk("sync_err_missing", bus.sync_err, 1'b1);
                void'(eq.pop_front());
            end
        end
    end

    task automatic send_bit(input logic d, input logic f, input logic en);
        bus.din   = d;
        bus.frame = f;
        bus.en    = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.en    = 1'b0;
        bus.frame = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame; optional en=0 gap (with frame high) inside slot 2.
    task automatic send_frame(input words_t w, input logic mark, input int gap,
                              input bit exp_err, input bit exp_out);
        int start;
        start = cyc;
        for (int s = 0; s < 4; s++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                if (s == 2 && b == DW - 2) repeat (gap) send_bit(1'b0, 1'b1, 1'b0);
                send_bit(w[s][b], mark && s == 0 && b == DW - 1, 1'b1);
                if (s == 0 && b == DW - 1) begin
                    if (exp_err) eq.push_back(start + 1);
                    if (mark) chk("locked_after_marker", bus.locked, 1'b1);
                end
            end
        end
        if (exp_out) begin
            fq.push_back('{w, start + 4 * DW + gap});
            last_w = w;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_o0"}, bus.o0, '0);
        chk({tag, "_o1"}, bus.o1, '0);
        chk({tag, "_o2"}, bus.o2, '0);
        chk({tag, "_o3"}, bus.o3, '0);
        chk({tag, "_fv"}, bus.frame_valid, 1'b0);
        chk({tag, "_locked"}, bus.locked, 1'b0);
        chk({tag, "_sync_err"}, bus.sync_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en    = 1'b0;
        bus.din   = 1'b0;
        bus.frame = 1'b0;
        last_w    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("init");
        rst = 1'b0;
        idle(2);

        // Basic frame A,5,C,3.
        send_frame({4'h3, 4'hC, 4'h5, 4'hA}, 1'b1, 0, 1'b0, 1'b1);
        idle(3);

        // Same frame with a 3-cycle en gap in slot 2, marker high during gap.
        send_frame({4'h3, 4'hC, 4'h5, 4'hA}, 1'b1, 3, 1'b0, 1'b1);
        idle(3);

        // Early marker at slot 1 bit 2, then full frame 9,1,2,E from it.
        send_bit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, 1'b1);
        send_frame({4'hE, 4'h2, 4'h1, 4'h9}, 1'b1, 0, 1'b1, 1'b1);
        idle(3);

        // One missing marker: flywheel keeps the frame.
        send_frame({4'hD, 4'h0, 4'hB, 4'h7}, 1'b0, 0, 1'b1, 1'b1);
        chk("locked_after_one_miss", bus.locked, 1'b1);
        // Second consecutive miss: drop to HUNT, outputs hold.
        send_frame({4'hF, 4'hF, 4'hF, 4'hF}, 1'b0, 0, 1'b1, 1'b0);
        chk("locked_after_two_miss", bus.locked, 1'b0);
        chk("hold_o0", bus.o0, 4'h7);
        chk("hold_o1", bus.o1, 4'hB);
        chk("hold_o2", bus.o2, 4'h0);
        chk("hold_o3", bus.o3, 4'hD);
        send_frame({4'h8, 4'h6, 4'h4, 4'h2}, 1'b1, 0, 1'b0, 1'b1);
        idle(3);

        // Back-to-back frames.
        send_frame({4'h4, 4'h3, 4'h2, 4'h1}, 1'b1, 0, 1'b0, 1'b1);
        send_frame({4'hB, 4'hA, 4'h9, 4'h8}, 1'b1, 0, 1'b0, 1'b1);
        send_frame({4'hF, 4'hE, 4'hD, 4'hC}, 1'b1, 0, 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset mid-frame.
        send_bit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame({4'h5, 4'h5, 4'h5, 4'h5}, 1'b0, 0, 1'b0, 1'b0);
        chk("locked_no_marker_after_rst", bus.locked, 1'b0);
        send_frame({4'h1, 4'hC, 4'h6, 4'h3}, 1'b1, 0, 1'b0, 1'b1);
        idle(4);

        chk("frames_pending", fq.size(), 0);
        chk("sync_err_pending", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
